// File: rtl/snes_rom_loader.sv
// snes_rom_loader: captures the SNES header of a ROM load and streams the payload to SDRAM as 16-bit words
// Ports:
//   clk, resetn                 clock and synchronous active-low reset
//   rom_loading/rom_do/_valid   byte stream from iosys; level marks a load, strobe per byte
//   mem_req/addr/wdata/ready    SDRAM word write: req held until a one-cycle ready pulse
//   map_ctrl..ram_size          header bytes 0x15..0x18
//   rom_mask, ram_mask          address masks decoded from the header size bytes
//   header_valid, rom_loaded    header captured / load finished with all writes done
//   error                       sticky: word dropped on FIFO full or address overflow
module snes_rom_loader #(
  parameter int ADDR_WIDTH = 23,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rom_loading,
  input  logic [7:0]            rom_do,
  input  logic                  rom_do_valid,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-2:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic                  mem_ready,
  output logic [7:0]            map_ctrl,
  output logic [7:0]            rom_type,
  output logic [7:0]            rom_size,
  output logic [7:0]            ram_size,
  output logic [22:0]           rom_mask,
  output logic [19:0]           ram_mask,
  output logic                  header_valid,
  output logic                  rom_loaded,
  output logic                  error
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int EW = ADDR_WIDTH + 15;
  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;
  state_t state;
  logic loading_q, pend, over, stale;
  logic [6:0] hdr_cnt;
  logic [ADDR_WIDTH-1:0] n;
  logic [7:0] low;
  logic [EW-1:0] fifo [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0] count;
  logic rise, fall, hdr, pay, word_done, push_try, full, push, pop;
  logic [EW-1:0] push_word;
  logic [22:0] rom_mask_d;
  logic [19:0] ram_mask_d;
  // A byte arriving with the falling edge is folded into the flush, so at most
  // one word is pushed per cycle. The word address is n>>1 in every case: a
  // pending even byte leaves n odd but still inside the same word.
  always_comb begin
    rise = rom_loading & ~loading_q;
    fall = ~rom_loading & loading_q;
    hdr = (state == LOAD) & rom_do_valid & ~hdr_cnt[6];
    pay = (state == LOAD) & rom_do_valid & hdr_cnt[6];
    word_done = pay & n[0];
    push_try = word_done | ((state == LOAD) & fall & (pay ? ~n[0] : pend));
    full = count == (PW+1)'(FIFO_DEPTH);
    push = push_try & ~over & ~full;
    pop = mem_req & mem_ready & ~stale;
    push_word = {n[ADDR_WIDTH-1:1], word_done ? rom_do : 8'h00, (pay & ~n[0]) ? rom_do : low};
    rom_mask_d = (rom_size >= 8'd13) ? '1 : (23'd1024 << rom_size) - 23'd1;
    ram_mask_d = (ram_size == 8'd0) ? '0 : (ram_size >= 8'd10) ? '1 : (20'd1024 << ram_size) - 20'd1;
  end
  always_ff @(posedge clk)
    if (push) fifo[wr_ptr] <= push_word;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      loading_q <= 1'b0;
      pend <= 1'b0;
      over <= 1'b0;
      stale <= 1'b0;
      hdr_cnt <= '0;
      n <= '0;
      low <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      mem_req <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      map_ctrl <= '0;
      rom_type <= '0;
      rom_size <= '0;
      ram_size <= '0;
      rom_mask <= '0;
      ram_mask <= '0;
      header_valid <= 1'b0;
      rom_loaded <= 1'b0;
      error <= 1'b0;
    end else begin
      loading_q <= rom_loading;
      if (rise) begin
        state <= LOAD;
        pend <= 1'b0;
        over <= 1'b0;
        hdr_cnt <= '0;
        n <= '0;
        wr_ptr <= '0;
        rd_ptr <= '0;
        count <= '0;
        map_ctrl <= '0;
        rom_type <= '0;
        rom_size <= '0;
        ram_size <= '0;
        rom_mask <= '0;
        ram_mask <= '0;
        header_valid <= 1'b0;
        rom_loaded <= 1'b0;
        error <= 1'b0;
      end else begin
        if (state == LOAD && fall) state <= DRAIN;
        else if (state == DRAIN && count == '0 && !mem_req) state <= DONE;
        if (hdr) begin
          hdr_cnt <= hdr_cnt + 7'd1;
          if (hdr_cnt == 7'h15) map_ctrl <= rom_do;
          if (hdr_cnt == 7'h16) rom_type <= rom_do;
          if (hdr_cnt == 7'h17) rom_size <= rom_do;
          if (hdr_cnt == 7'h18) ram_size <= rom_do;
          if (hdr_cnt == 7'd63) begin
            header_valid <= 1'b1;
            rom_mask <= rom_mask_d;
            ram_mask <= ram_mask_d;
          end
        end
        // over marks byte counts past the address range; n keeps wrapping so parity stays right
        if (pay) begin
          n <= n + ADDR_WIDTH'(1);
          over <= over | (&n);
          pend <= ~n[0];
          if (!n[0]) low <= rom_do;
        end
        if (fall) pend <= 1'b0;
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
        if (push_try & (over | full)) error <= 1'b1;
        if (state == DONE) rom_loaded <= 1'b1;
      end
      // A request left over from a previous load completes without popping the freshly cleared FIFO
      if (mem_req) mem_req <= ~mem_ready;
      else if (count != '0 && !rise) begin
        mem_req <= 1'b1;
        {mem_addr, mem_wdata} <= fifo[rd_ptr];
      end
      stale <= mem_req & ~mem_ready & (stale | rise);
    end
  end
endmodule

// File: tb/tb_snes_rom_loader.sv
// tb_snes_rom_loader: directed and randomized loads checked against a word-level model of the loader
module tb_snes_rom_loader;
  localparam int AW = 8;
  localparam int DEPTH = 4;
  logic clk = 0, resetn = 0, rom_loading = 0, rom_do_valid = 0, mem_ready = 0;
  logic [7:0] rom_do = 0;
  logic mem_req;
  logic [AW-2:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [7:0] map_ctrl, rom_type, rom_size, ram_size;
  logic [22:0] rom_mask;
  logic [19:0] ram_mask;
  logic header_valid, rom_loaded, error;
  int checks = 0, errors = 0;
  int hold = 0, dly = 0, rand_dly = 0, stray = 0, busy = 0, wcnt = 0, acked = 0;
  logic [AW-2:0] cap_addr;
  logic [15:0] cap_data;
  logic [AW+14:0] obs_q[$], exp_q[$];
  logic [7:0] hdr[64];
  logic [7:0] pay[$];

  always #5 clk = ~clk;

  snes_rom_loader #(.ADDR_WIDTH(AW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .rom_loading(rom_loading), .rom_do(rom_do),
    .rom_do_valid(rom_do_valid), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .map_ctrl(map_ctrl),
    .rom_type(rom_type), .rom_size(rom_size), .ram_size(ram_size),
    .rom_mask(rom_mask), .ram_mask(ram_mask), .header_valid(header_valid),
    .rom_loaded(rom_loaded), .error(error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // SDRAM side: records each request once, checks it stays stable, answers with ready after dly cycles
  initial forever begin
    @(negedge clk);
    if (acked != 0) check("req_drop", 32'(mem_req), 32'd0);
    acked = 0;
    mem_ready = 0;
    if (!mem_req) busy = 0;
    else if (busy == 0) begin
      busy = 1;
      wcnt = 0;
      cap_addr = mem_addr;
      cap_data = mem_wdata;
      obs_q.push_back({mem_addr, mem_wdata});
      if (rand_dly != 0) dly = int'($urandom_range(0, 3));
    end else begin
      check("addr_stable", 32'(mem_addr), 32'(cap_addr));
      check("data_stable", 32'(mem_wdata), 32'(cap_data));
    end
    if (busy != 0 && hold == 0) begin
      if (wcnt == dly) begin
        mem_ready = 1;
        acked = 1;
      end
      wcnt++;
    end else if (busy == 0 && stray != 0) mem_ready = ($urandom_range(0, 3) == 0);
  end

  function automatic int mask_rom(input int rs);
    return rs >= 13 ? 32'h7FFFFF : (1024 << rs) - 1;
  endfunction

  function automatic int mask_ram(input int rs);
    return rs == 0 ? 0 : rs >= 10 ? 32'hFFFFF : (1024 << rs) - 1;
  endfunction

  // Word-level reference: payload bytes pair up little-endian, a lone last byte is zero-padded,
  // words beyond the address range or beyond the buffering capacity are dropped and flag an error
  task automatic model(input int cap, output logic exp_err);
    int nw, kept;
    logic [15:0] d;
    nw = (pay.size() + 1) / 2;
    kept = 0;
    exp_err = 0;
    exp_q.delete();
    for (int w = 0; w < nw; w++) begin
      d = {(2*w+1 < pay.size()) ? pay[2*w+1] : 8'h00, pay[2*w]};
      if (w >= (1 << (AW-1)) || kept >= cap) exp_err = 1;
      else begin
        exp_q.push_back({w[AW-2:0], d});
        kept++;
      end
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    rom_do = b;
    rom_do_valid = 1;
    tick(1);
    rom_do_valid = 0;
    tick(gap);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, 32'(mem_req), 32'd0);
    check({tag, "_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_fields"}, {map_ctrl, rom_type, rom_size, ram_size}, 32'd0);
    check({tag, "_rom_mask"}, 32'(rom_mask), 32'd0);
    check({tag, "_ram_mask"}, 32'(ram_mask), 32'd0);
    check({tag, "_flags"}, 32'({header_valid, rom_loaded, error}), 32'd0);
  endtask

  task automatic rand_header(input int rs, input int ms);
    for (int i = 0; i < 64; i++) hdr[i] = 8'($urandom);
    hdr[23] = 8'(rs);
    hdr[24] = 8'(ms);
  endtask

  task automatic send_header();
    for (int i = 0; i < 64; i++) begin
      if (i == 63) check("hv_early", 32'(header_valid), 32'd0);
      send(hdr[i], 0);
    end
    check("header_valid", 32'(header_valid), 32'd1);
    check("map_ctrl", 32'(map_ctrl), 32'(hdr[21]));
    check("rom_type", 32'(rom_type), 32'(hdr[22]));
    check("rom_size", 32'(rom_size), 32'(hdr[23]));
    check("ram_size", 32'(ram_size), 32'(hdr[24]));
    check("rom_mask", 32'(rom_mask), 32'(mask_rom(int'(hdr[23]))));
    check("ram_mask", 32'(ram_mask), 32'(mask_ram(int'(hdr[24]))));
  endtask

  task automatic finish_load(input int cap);
    int k;
    logic e;
    rom_loading = 0;
    tick(1);
    k = 0;
    while (!rom_loaded && k < 2000) begin
      tick(1);
      k++;
    end
    check("rom_loaded", 32'(rom_loaded), 32'd1);
    model(cap, e);
    check("error", 32'(error), 32'(e));
    check("write_count", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("write%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
    obs_q.delete();
  endtask

  task automatic run_load(input int glo, input int ghi, input bit merge);
    rom_loading = 1;
    tick(1);
    send_header();
    for (int i = 0; i < pay.size(); i++) begin
      if (merge && i == pay.size() - 1) begin
        rom_do = pay[i];
        rom_do_valid = 1;
        rom_loading = 0;
        tick(1);
        rom_do_valid = 0;
      end else send(pay[i], int'($urandom_range(glo, ghi)));
    end
    finish_load(1000);
  endtask

  initial begin
    tick(3);
    check_zero("reset");
    resetn = 1;
    tick(2);
    // header decode, no payload
    rand_header(8'h0A, 8'h03);
    hdr[21] = 8'h20;
    pay.delete();
    run_load(0, 0, 0);
    check("t1_map_ctrl", 32'(map_ctrl), 32'h20);
    check("t1_rom_mask", 32'(rom_mask), 32'h0FFFFF);
    check("t1_ram_mask", 32'(ram_mask), 32'h01FFF);
    // two words back-to-back, slow ready
    dly = 3;
    rand_header(1, 1);
    pay = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_load(0, 0, 0);
    // odd tail flushed at load end, with strobe-to-request latency
    rom_loading = 1;
    tick(1);
    send_header();
    check("no_req_hdr", 32'(obs_q.size()), 32'd0);
    send(8'h11, 0);
    send(8'h22, 0);
    check("req_lat1", 32'(mem_req), 32'd0);
    tick(1);
    check("req_lat2", 32'(mem_req), 32'd1);
    check("req_lat_word", {mem_addr, mem_wdata}, 32'h2211);
    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send(8'h33, 0);
    send(8'h44, 0);
    send(8'h55, 0);
    finish_load(1000);
    // FIFO overflow with ready held off
    dly = 0;
    hold = 1;
    rom_loading = 1;
    tick(1);
    send_header();
    pay.delete();
    for (int i = 0; i < 12; i++) begin
      pay.push_back(8'(i + 1));
      send(8'(i + 1), 0);
    end
    tick(2);
    check("fifo_err", 32'(error), 32'd1);
    check("fifo_req", 32'(mem_req), 32'd1);
    hold = 0;
    finish_load(DEPTH);
    // address range boundary: exactly full range, then two bytes beyond
    dly = 1;
    pay.delete();
    for (int i = 0; i < 256; i++) pay.push_back(8'($urandom));
    run_load(3, 3, 0);
    pay.push_back(8'hC3);
    pay.push_back(8'h3C);
    run_load(3, 3, 0);
    // new load while a request is outstanding
    dly = 0;
    hold = 1;
    rom_loading = 1;
    tick(1);
    send_header();
    for (int i = 0; i < 12; i++) send(8'(8'hA0 + i), 0);
    check("rs_err_before", 32'(error), 32'd1);
    rom_loading = 0;
    tick(2);
    check("rs_req_pending", 32'(mem_req), 32'd1);
    rom_loading = 1;
    tick(1);
    check("rs_hv", 32'(header_valid), 32'd0);
    check("rs_err", 32'(error), 32'd0);
    check("rs_req_word", {mem_addr, mem_wdata}, 32'hA1A0);
    tick(3);
    check("rs_req_held", 32'(mem_req), 32'd1);
    hold = 0;
    tick(6);
    check("rs_req_done", 32'(mem_req), 32'd0);
    check("rs_fifo_empty", 32'(obs_q.size()), 32'd1);
    check("rs_stale_write", 32'(obs_q.pop_front()), 32'hA1A0);
    rand_header(5, 0);
    send_header();
    pay = '{8'h5A, 8'h5B, 8'h5C};
    send(8'h5A, 2);
    send(8'h5B, 2);
    send(8'h5C, 2);
    finish_load(1000);
    // reset in the middle of a load with a request pending
    hold = 1;
    rom_loading = 1;
    tick(1);
    send_header();
    for (int i = 0; i < 4; i++) send(8'($urandom), 0);
    tick(2);
    check("mid_req", 32'(mem_req), 32'd1);
    resetn = 0;
    rom_loading = 0;
    tick(1);
    check_zero("mid_reset");
    tick(2);
    resetn = 1;
    hold = 0;
    tick(2);
    obs_q.delete();
    // randomized loads with random ready latency and stray ready pulses
    rand_dly = 1;
    stray = 1;
    for (int t = 0; t < 8; t++) begin
      rand_header(int'($urandom_range(0, 15)), int'($urandom_range(0, 12)));
      pay.delete();
      for (int i = 0; i < int'($urandom_range(0, 40)); i++) pay.push_back(8'($urandom));
      run_load(3, 5, $urandom_range(0, 1) == 1);
    end
    rand_dly = 0;
    stray = 0;
    tick(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/snes_rom_loader.md
# snes_rom_loader

Consumes the byte stream produced by the IO subsystem's ROM-loading port (`rom_loading`, `rom_do`, `rom_do_valid`) and turns it into SDRAM writes plus decoded cartridge header information. The first 64 bytes of each load are the SNES header block, which is captured and decoded into map/size masks for the SNES core. All later bytes are packed into 16-bit words, buffered in a small FIFO and written to SDRAM through a level/pulse request handshake. It sits between iosys and the SDRAM arbiter's ROM write port.

## Interface
- `ADDR_WIDTH`, 23: SDRAM byte-address width; word address is `[ADDR_WIDTH-1:1]`.
- `FIFO_DEPTH`, 4: word FIFO entries; power of two, at least 2.
- `clk` in 1: SNES mclk; all logic on the rising edge.
- `resetn` in 1: reset, synchronous, active-low; clock `clk`.
- `rom_loading` in 1: 0→1 starts a load, 1→0 ends it.
- `rom_do` in 8: stream byte.
- `rom_do_valid` in 1: one-cycle strobe per byte.
- `mem_req` out 1: write request, held until `mem_ready`.
- `mem_addr` out ADDR_WIDTH-1: word address.
- `mem_wdata` out 16: write data, little-endian byte pair.
- `mem_ready` in 1: one-cycle completion pulse.
- `map_ctrl`, `rom_type`, `rom_size`, `ram_size` out 8 each: header bytes at offsets 0x15–0x18.
- `rom_mask` out 23: ROM byte-address mask.
- `ram_mask` out 20: cartridge RAM byte-address mask.
- `header_valid` out 1: header block fully received.
- `rom_loaded` out 1: load finished and all writes completed.
- `error` out 1: sticky; set on FIFO overflow or address overflow.

## Operation
- **States:**
  - IDLE → LOAD on a `rom_loading` rising edge.
  - LOAD → DRAIN on a falling edge.
  - DRAIN → DONE when the FIFO is empty and no request is outstanding.
  - DONE → LOAD on the next rising edge.
  - Bytes are accepted only in LOAD.
- **Load start (rising edge):** clears the byte counter, the FIFO, `header_valid`, `rom_loaded`, `error` and the field registers.
  - An outstanding `mem_req` stays asserted, with stable address and data, until its `mem_ready`. Its data is not re-issued.
- **Header bytes (counter 0..63):**
  - Offsets 0x15, 0x16, 0x17 and 0x18 are latched into `map_ctrl`, `rom_type`, `rom_size` and `ram_size`.
  - No header byte is written to SDRAM.
- **Header decode:**
  - `rom_mask` = (1024 << `rom_size`) − 1, saturated to all-ones for `rom_size` ≥ 13.
  - `ram_mask` = 0 if `ram_size` = 0; otherwise (1024 << `ram_size`) − 1, saturated to all-ones (20 bits) for `ram_size` ≥ 10.
- **Packing (counter ≥ 64):**
  - Payload byte n (n = counter − 64) goes to byte address n.
  - An even n is held as the low byte. The following odd byte completes the word {odd, even}, which is pushed at word address n>>1.
- **Load end (falling edge):** if an even byte is pending, push {8'h00, byte}.
- **FIFO full:** an incoming completed word is dropped and `error` is set.
- **Address overflow:** a word whose address exceeds the word-address range is dropped and `error` is set. The address does not wrap.
- **Simultaneous events:** a `rom_do_valid` in the same cycle as the falling edge is accepted before the end-of-load flush.

## Timing
- **Reset values:** every output is 0, and the FSM is in IDLE.
- **Header fields:** each field register updates the cycle after its strobe.
- **`header_valid`, `rom_mask`, `ram_mask`:** valid the cycle after byte 63 is accepted.
- **Write latency:** the word is in the FIFO one cycle after the odd-byte strobe. `mem_req` rises the following cycle if the FIFO was empty and no request is outstanding (2 cycles from strobe to request).
- **Handshake:**
  - `mem_addr` and `mem_wdata` are stable while `mem_req` = 1.
  - In the cycle `mem_ready` = 1, the FIFO pops. `mem_req` drops the next cycle.
  - At least one idle cycle separates requests.
  - A `mem_ready` while `mem_req` = 0 is ignored.
- **FIFO occupancy:** a push and a pop in the same cycle leave the count unchanged.
- **Input rate:** the block accepts one byte per cycle continuously. A 4-byte burst from iosys fills at most 2 entries.
- **`rom_loaded`:** rises the cycle after entering DONE. It falls the cycle after a new rising edge.

## Test plan
- Stream 64 header bytes with 0x15=0x20, 0x17=0x0A, 0x18=0x03 → `map_ctrl`=0x20, `rom_mask`=0x0FFFFF, `ram_mask`=0x01FFF, `header_valid`=1 one cycle after byte 63; no `mem_req` during the header.
- Header, then payload 0x11,0x22,0x33,0x44 back-to-back, `mem_ready` 3 cycles after each request → writes (0,0x2211), (1,0x4433) in order; `rom_loaded`=1 after the second ready and the falling edge.
- Header, then 5 payload bytes, then `rom_loading` falls → third write is (2, 0x0055); `rom_loaded` follows.
- Hold `mem_ready` low and send 12 payload bytes with `FIFO_DEPTH`=4 → 4 words queued, remaining words dropped, `error`=1; release ready → exactly 4 writes.
- Raise `rom_loading` again while `mem_req` is pending → request stays until ready; FIFO is empty afterwards; `header_valid`=0 and `error`=0; new payload restarts at word 0.
- Assert `resetn`=0 mid-load → all outputs 0 the next cycle and `mem_req` drops immediately.
